// File: rtl/pacman_soc_spi_slave.sv
// pacman_soc_spi_slave
//   SPI slave (mode 0: CPOL=0, CPHA=0, MSB first) with a memory-mapped CPU
//   register port. SCLK, SS_n and MOSI come from an external master and are
//   synchronised and edge-detected in the clk domain. The SCLK high and low
//   phases must each last at least 4 clk.
//
//   Register map (mem_addr):
//     0 rxdata  (r)  last completed frame; reading clears RRDY
//     1 txdata  (w)  byte for the next frame; reads return rxdata
//     2 status  (r)  {E,RRDY,TRDY,TMT,TOE,ROE} at bits 8..3; any write clears flags
//     3 control (rw) {iE,iRRDY,iTRDY,-,iTOE,iROE} at bits 8..3
//     4-7            reads return rxdata, writes ignored
//
// Ports
//   clk, reset_n              system clock, asynchronous active-low reset
//   SCLK, SS_n, MOSI, MISO    SPI pins; MISO is 0 whenever the slave is idle
//   spi_select, mem_addr,
//   read_n, write_n,
//   data_from_cpu             CPU register access request
//   data_to_cpu               registered read data
//   irq                       registered interrupt request
//   dataavailable             RRDY
//   readyfordata              TRDY
//
// CPU access protocol: an access is requested while spi_select is high and
// read_n or write_n is low. It takes effect exactly once, on the first clk
// edge of the request (strobe_q masks the following cycles); the request is
// held for two cycles and data_to_cpu is valid from the second cycle onward
// and keeps its value until the next read.
module pacman_soc_spi_slave #(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);

    localparam int CW = $clog2(DATABITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATABITS - 1);
    localparam logic [CW-1:0] FULL     = CW'(DATABITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t state;

    // Synchronisers; the extra history flop gives one-cycle edge pulses.
    // SS_n resets to 0 so a select already low at reset release does not
    // look like a falling edge.
    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic sclk_hist, ss_hist;
    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic [DATABITS-1:0] rx_shift, tx_shift, rx_holding, tx_holding;
    logic [CW-1:0]       bitcnt;
    logic                tx_primed, rrdy, toe, roe;
    logic                ie, irrdy, itrdy, itoe, iroe;
    logic                strobe_q;

    logic                rd_stb, wr_stb, rd_rx, wr_tx, wr_status, wr_ctrl;
    logic                trdy, tmt, err, frame_done;
    logic [DATABITS-1:0] rx_next;
    logic [15:0]         status_word, control_word, rd_mux;
    logic                unused_bits;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign ss_rise   = ss_s & ~ss_hist;
    assign ss_fall   = ~ss_s & ss_hist;

    assign rd_stb    = ~strobe_q & spi_select & ~read_n;
    assign wr_stb    = ~strobe_q & spi_select & ~write_n;
    assign rd_rx     = rd_stb & (mem_addr == 3'd0);
    assign wr_tx     = wr_stb & (mem_addr == 3'd1);
    assign wr_status = wr_stb & (mem_addr == 3'd2);
    assign wr_ctrl   = wr_stb & (mem_addr == 3'd3);

    assign trdy = ~tx_primed;
    assign tmt  = ~tx_primed & (state == IDLE);
    assign err  = toe | roe;

    assign status_word  = {7'b0, err, rrdy, trdy, tmt, toe, roe, 3'b000};
    assign control_word = {7'b0, ie, irrdy, itrdy, 1'b0, itoe, iroe, 3'b000};

    assign rx_next    = {rx_shift[DATABITS-2:0], mosi_s};
    // The DATABITS-th rising edge completes the frame unless the master is
    // deselecting in the same cycle.
    assign frame_done = (state == SHIFT) & ~ss_rise & sclk_rise & (bitcnt == LAST_BIT);

    assign MISO          = (state != IDLE) & tx_shift[DATABITS-1];
    assign dataavailable = rrdy;
    assign readyfordata  = trdy;

    assign unused_bits = ^data_from_cpu[15:9];

    always_comb begin
        rd_mux = 16'(rx_holding);
        case (mem_addr)
            3'd2:    rd_mux = status_word;
            3'd3:    rd_mux = control_word;
            default: rd_mux = 16'(rx_holding);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync   <= '0;
            ss_sync     <= '0;
            mosi_sync   <= '0;
            sclk_hist   <= 1'b0;
            ss_hist     <= 1'b0;
            state       <= IDLE;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_holding  <= '0;
            tx_holding  <= '0;
            bitcnt      <= '0;
            tx_primed   <= 1'b0;
            rrdy        <= 1'b0;
            toe         <= 1'b0;
            roe         <= 1'b0;
            ie          <= 1'b0;
            irrdy       <= 1'b0;
            itrdy       <= 1'b0;
            itoe        <= 1'b0;
            iroe        <= 1'b0;
            strobe_q    <= 1'b0;
            data_to_cpu <= '0;
            irq         <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_hist <= sclk_s;
            ss_hist   <= ss_s;

            strobe_q <= spi_select & (~read_n | ~write_n);
            if (rd_stb) data_to_cpu <= rd_mux;

            irq <= (err & ie) | (rrdy & irrdy) | (trdy & itrdy) | (toe & itoe) | (roe & iroe);

            // Deselect aborts any frame in progress; the partial byte is dropped.
            if (state != IDLE && ss_rise) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (ss_fall) state <= LOAD;
                    LOAD: begin
                        tx_shift  <= tx_primed ? tx_holding : '0;
                        tx_primed <= 1'b0;
                        bitcnt    <= '0;
                        state     <= SHIFT;
                    end
                    SHIFT: begin
                        if (sclk_rise && bitcnt != FULL) begin
                            rx_shift <= rx_next;
                            bitcnt   <= bitcnt + CW'(1);
                        end else if (sclk_fall) begin
                            // The falling edge after a full frame starts the
                            // next one instead of shifting.
                            if (bitcnt == FULL) state <= LOAD;
                            else tx_shift <= {tx_shift[DATABITS-2:0], 1'b0};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (frame_done) begin
                rx_holding <= rx_next;
                rrdy       <= 1'b1;
            end else if (rd_rx || wr_status) begin
                rrdy <= 1'b0;
            end

            if (wr_status)                     roe <= 1'b0;
            else if (frame_done && rrdy && !rd_rx) roe <= 1'b1;

            if (wr_status)               toe <= 1'b0;
            else if (wr_tx && tx_primed) toe <= 1'b1;

            // Placed after LOAD so an accepted write in the LOAD cycle re-primes
            // for the following frame.
            if (wr_tx && !tx_primed) begin
                tx_holding <= data_from_cpu[DATABITS-1:0];
                tx_primed  <= 1'b1;
            end

            if (wr_ctrl) begin
                ie    <= data_from_cpu[8];
                irrdy <= data_from_cpu[7];
                itrdy <= data_from_cpu[6];
                itoe  <= data_from_cpu[4];
                iroe  <= data_from_cpu[3];
            end
        end
    end

endmodule
